fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Three-stage instruction fetch front end (PC, memory read,
//               decoded output register) with stall, branch redirect and HALT.
//               Optional accepted-instruction counter: define FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [3:0]      opcode,
    output logic [1:0]      format,
    output logic            imm_flag,
    output logic [8:0]      operand,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_out,
    output logic            halted,
    output logic            done,
    output logic [15:0]     instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0]      C_OP_HALT = 4'b1110;
    localparam logic [PC_W-1:0] C_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_fetch_addr;
    logic            r_rd_valid;
    logic [15:0]     r_instr;
    logic            r_instr_valid;
    logic [PC_W-1:0] r_pc_out;
    logic            r_done;

    logic w_run;
    logic w_advance;
    logic w_accept;
    logic w_halt_accept;
    logic w_redirect;
    logic w_launch;

    assign w_run         = (r_state == RUN);
    assign w_advance     = w_run && !stall;
    assign w_accept      = w_advance && r_instr_valid;
    assign w_halt_accept = w_accept && (r_instr[15:12] == C_OP_HALT);
    // A halting instruction wins over a branch presented in the same cycle.
    assign w_redirect    = w_advance && branch_taken && !w_halt_accept;
    assign w_launch      = start && !w_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)         w_state_nxt = RUN;
            RUN:     if (w_halt_accept) w_state_nxt = HALT;
            HALT:    if (start)         w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_fetch_addr  <= '0;
            r_rd_valid    <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_pc_out      <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_halt_accept;
            if (w_launch) begin
                r_pc          <= start_addr;
                r_rd_valid    <= 1'b0;
                r_instr_valid <= 1'b0;
            end else if (w_halt_accept) begin
                r_rd_valid    <= 1'b0;
                r_instr_valid <= 1'b0;
            end else if (w_advance) begin
                r_pc          <= w_redirect ? branch_target : (r_pc + C_PC_ONE);
                r_fetch_addr  <= r_pc;
                r_rd_valid    <= !w_redirect;
                r_instr_valid <= r_rd_valid && !w_redirect;
                // Keep the decode fields stable while no word is in flight.
                if (r_rd_valid) begin
                    r_instr  <= imem_rdata;
                    r_pc_out <= r_fetch_addr;
                end
            end
        end
    end

    // While stalled, re-read the word held in the read stage so it is re-presented.
    assign imem_addr = (w_run && stall) ? r_fetch_addr : r_pc;

    assign opcode      = r_instr[15:12];
    assign format      = r_instr[11:10];
    assign imm_flag    = r_instr[9];
    assign operand     = r_instr[8:0];
    assign instr_valid = r_instr_valid;
    assign pc_out      = r_pc_out;
    assign halted      = (r_state == HALT);
    assign done        = r_done;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (w_accept && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with directed scenarios and
//               a randomized stall/branch run against a stream-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [3:0]  opcode;
    logic [1:0]  format;
    logic        imm_flag;
    logic [8:0]  operand;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        halted;
    logic        done;
    logic [15:0] instr_count;

    logic [15:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_unit #(.PC_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .opcode(opcode), .format(format), .imm_flag(imm_flag), .operand(operand),
        .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted), .done(done),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for the address of one cycle appears the next.
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic fill_mem();
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hE) w[15:12] = 4'hF;
            mem[i] = w;
        end
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic launch(input logic [7:0] a);
        cyc(); start = 1'b1; start_addr = a;
        cyc(); start = 1'b0; start_addr = 8'h99;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc(); #1;
        n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 00", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if ({opcode, format, imm_flag, operand} !== 16'h0000) begin n_fail++; $display("FAIL reset_fields: got %h want 0000", {opcode, format, imm_flag, operand}); end
        n_checks++; if (pc_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc_out: got %h want 00", pc_out); end
        n_checks++; if ({halted, done} !== 2'b00) begin n_fail++; $display("FAIL reset_halt_done: got %b want 00", {halted, done}); end
        n_checks++; if (instr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h want 0000", instr_count); end
        reset = 1'b0;
    endtask

    task automatic test_start();
        do_reset();
        launch(8'h10); #1;
        n_checks++; if (imem_addr !== 8'h10) begin n_fail++; $display("FAIL start_fetch0: got %h want 10", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL start_valid0: got %b want 0", instr_valid); end
        cyc(); #1;
        n_checks++; if (imem_addr !== 8'h11) begin n_fail++; $display("FAIL start_fetch1: got %h want 11", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL start_valid1: got %b want 0", instr_valid); end
        cyc(); #1;
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h10) begin n_fail++; $display("FAIL start_first: valid=%b pc_out=%h want 1/10", instr_valid, pc_out); end
        n_checks++; if ({opcode, format, imm_flag, operand} !== mem[8'h10]) begin n_fail++; $display("FAIL start_fields: got %h want %h", {opcode, format, imm_flag, operand}, mem[8'h10]); end
        n_checks++; if (imem_addr !== 8'h12) begin n_fail++; $display("FAIL start_fetch2: got %h want 12", imem_addr); end
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL start_stream: valid=%b pc_out=%h want 1/%h", instr_valid, pc_out, 8'(8'h10 + i)); end
        end
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        do_reset();
        launch(8'h10);
        for (int k = 0; k < 20 && !found; k++) begin
            #1; if (instr_valid === 1'b1 && pc_out === 8'h12) found = 1'b1; else cyc();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL stall_reach: pc_out 12 not seen, got %h", pc_out); end
        stall = 1'b1; #1;
        n_checks++; if (imem_addr !== 8'h13) begin n_fail++; $display("FAIL stall_imem_addr: got %h want 13", imem_addr); end
        for (int s = 0; s < 2; s++) begin
            cyc(); #1;
            n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h12) begin n_fail++; $display("FAIL stall_hold_pc: valid=%b pc_out=%h want 1/12", instr_valid, pc_out); end
            n_checks++; if ({opcode, format, imm_flag, operand} !== mem[8'h12]) begin n_fail++; $display("FAIL stall_hold_fields: got %h want %h", {opcode, format, imm_flag, operand}, mem[8'h12]); end
        end
        cyc(); stall = 1'b0; #1;
        n_checks++; if (pc_out !== 8'h12) begin n_fail++; $display("FAIL stall_release: pc_out=%h want 12", pc_out); end
        for (int i = 1; i <= 2; i++) begin
            cyc(); #1;
            n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'(8'h12 + i)) begin n_fail++; $display("FAIL stall_after: valid=%b pc_out=%h want 1/%h", instr_valid, pc_out, 8'(8'h12 + i)); end
            n_checks++; if ({opcode, format, imm_flag, operand} !== mem[8'(8'h12 + i)]) begin n_fail++; $display("FAIL stall_after_fields: got %h want %h", {opcode, format, imm_flag, operand}, mem[8'(8'h12 + i)]); end
        end
    endtask

    task automatic test_branch();
        bit found = 1'b0;
        do_reset();
        launch(8'h00);
        for (int k = 0; k < 20 && !found; k++) begin
            #1; if (instr_valid === 1'b1 && pc_out === 8'h05) found = 1'b1; else cyc();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL branch_reach: pc_out 05 not seen, got %h", pc_out); end
        branch_taken = 1'b1; branch_target = 8'h40;
        for (int b = 0; b < 2; b++) begin
            cyc(); branch_taken = 1'b0; #1;
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL branch_bubble: valid=%b want 0", instr_valid); end
        end
        cyc(); #1;
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h40) begin n_fail++; $display("FAIL branch_target: valid=%b pc_out=%h want 1/40", instr_valid, pc_out); end
        n_checks++; if ({opcode, format, imm_flag, operand} !== mem[8'h40]) begin n_fail++; $display("FAIL branch_fields: got %h want %h", {opcode, format, imm_flag, operand}, mem[8'h40]); end
    endtask

    task automatic test_halt();
        bit found = 1'b0;
        mem[8'h03] = 16'hE000;
        do_reset();
        launch(8'h00);
        for (int k = 0; k < 20 && !found; k++) begin
            #1; if (instr_valid === 1'b1 && pc_out === 8'h03) found = 1'b1; else cyc();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL halt_reach: pc_out 03 not seen, got %h", pc_out); end
        branch_taken = 1'b1; branch_target = 8'h80;
        cyc(); branch_taken = 1'b0; #1;
        n_checks++; if ({halted, done, instr_valid} !== 3'b110) begin n_fail++; $display("FAIL halt_entry: halted/done/valid=%b want 110", {halted, done, instr_valid}); end
        for (int h = 0; h < 3; h++) begin
            cyc(); stall = 1'($urandom); branch_taken = 1'($urandom); #1;
            n_checks++; if ({halted, done, instr_valid} !== 3'b100) begin n_fail++; $display("FAIL halt_hold: halted/done/valid=%b want 100", {halted, done, instr_valid}); end
        end
        cyc(); stall = 1'b0; branch_taken = 1'b0; start = 1'b1; start_addr = 8'h00;
        mem[8'h03] = 16'h1234;
        cyc(); start = 1'b0; #1;
        n_checks++; if (halted !== 1'b0 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL halt_restart: halted=%b imem_addr=%h want 0/00", halted, imem_addr); end
        cyc(); cyc(); #1;
        n_checks++; if (instr_valid !== 1'b1 || pc_out !== 8'h00) begin n_fail++; $display("FAIL halt_restart_first: valid=%b pc_out=%h want 1/00", instr_valid, pc_out); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        do_reset();
        launch(8'hFE);
        cyc(); cyc(); #1;
        for (int i = 0; i < 4; i++) begin
            e = 8'(8'hFE + i);
            n_checks++; if (instr_valid !== 1'b1 || pc_out !== e) begin n_fail++; $display("FAIL wrap_pc_out: valid=%b pc_out=%h want 1/%h", instr_valid, pc_out, e); end
            cyc(); #1;
        end
        n_checks++; if (instr_count !== (PERF ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", instr_count, PERF ? 4 : 0); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        launch(8'h20);
        for (int i = 0; i < 5; i++) cyc();
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        n_checks++; if ({instr_valid, halted, done} !== 3'b000 || pc_out !== 8'h00 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL midrun_reset: v/h/d=%b pc_out=%h imem_addr=%h want 000/00/00", {instr_valid, halted, done}, pc_out, imem_addr); end
        n_checks++; if (instr_count !== 16'h0000) begin n_fail++; $display("FAIL midrun_count: got %h want 0000", instr_count); end
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h55;
        cyc(); stall = 1'b0; branch_taken = 1'b0; #1;
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL idle_ignore: valid=%b imem_addr=%h want 0/00", instr_valid, imem_addr); end
    endtask

    task automatic test_random();
        logic [7:0]  m_pc, m_exp;
        logic [15:0] m_cnt;
        int          m_fill;
        bit          v_exp;
        fill_mem();
        do_reset();
        m_pc = 8'($urandom);
        m_exp = m_pc; m_fill = 0; m_cnt = 16'd0;
        cyc(); start = 1'b1; start_addr = m_pc;
        for (int t = 0; t < 400; t++) begin
            cyc();
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 19) == 0);
            branch_target = 8'($urandom);
            start         = ($urandom_range(0, 29) == 0);
            start_addr    = 8'($urandom);
            #1;
            v_exp = (m_fill >= 2);
            n_checks++; if (instr_valid !== v_exp) begin n_fail++; $display("FAIL rnd_valid t=%0d: got %b want %b", t, instr_valid, v_exp); end
            if (v_exp) begin
                n_checks++; if (pc_out !== m_exp || {opcode, format, imm_flag, operand} !== mem[m_exp]) begin n_fail++; $display("FAIL rnd_instr t=%0d: pc_out=%h data=%h want %h/%h", t, pc_out, {opcode, format, imm_flag, operand}, m_exp, mem[m_exp]); end
            end
            if (!stall) begin
                n_checks++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_imem_addr t=%0d: got %h want %h", t, imem_addr, m_pc); end
            end else if (m_fill >= 1) begin
                n_checks++; if (imem_addr !== 8'(m_pc - 8'd1)) begin n_fail++; $display("FAIL rnd_imem_refetch t=%0d: got %h want %h", t, imem_addr, 8'(m_pc - 8'd1)); end
            end
            n_checks++; if (instr_count !== (PERF ? m_cnt : 16'd0)) begin n_fail++; $display("FAIL rnd_count t=%0d: got %0d want %0d", t, instr_count, PERF ? m_cnt : 16'd0); end
            if (!stall) begin
                if (v_exp) begin
                    m_exp = m_exp + 8'd1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                if (branch_taken) begin
                    m_pc = branch_target; m_exp = branch_target; m_fill = 0;
                end else begin
                    m_pc = m_pc + 8'd1;
                    if (m_fill < 2) m_fill++;
                end
            end
        end
        cyc(); start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_start();
        test_stall();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
